// File: rtl/instr_mem_sync_pkg.sv
// Shared constants for the nemesys instruction memory: opcode encodings,
// default sizes and the fetch-side FSM state type.
package instr_mem_sync_pkg;

  localparam int DATA_W      = 32;
  localparam int IMEM_ADDR_W = 8;
  localparam int OPCODE_W    = 5;

  localparam logic [OPCODE_W-1:0] OP_MOV  = 5'h01;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'h02;
  localparam logic [OPCODE_W-1:0] OP_MPY  = 5'h04;
  localparam logic [OPCODE_W-1:0] OP_CMP  = 5'h08;
  localparam logic [OPCODE_W-1:0] OP_BR   = 5'h0C;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'h1F;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/instr_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-address read and write returns the word held before the write.
module instr_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_W];
  logic [WIDTH-1:0] r_rdata;

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory with runtime load port, optional
// clear-to-HALT after reset, stall hold and out-of-range fault.
module instr_mem_sync
  import instr_mem_sync_pkg::*;
#(
  parameter int WIDTH          = DATA_W,
  parameter int ADDR_W         = IMEM_ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       pc,
  input  logic              stall,
  output logic [WIDTH-1:0]  inst,
  output logic              inst_valid,
  output logic              fault,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  output logic              busy
);

  localparam logic [WIDTH-1:0] HALT_WORD = {OP_HALT, {(WIDTH-OPCODE_W){1'b0}}};

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_valid;
  logic              r_fault;
  logic              r_selHalt;
  logic              r_loaded;
  logic              w_inInit;
  logic              w_outOfRange;
  logic              w_accept;
  logic              w_we;
  logic              w_re;
  logic [ADDR_W-1:0] w_waddr;
  logic [WIDTH-1:0]  w_wdata;
  logic [WIDTH-1:0]  w_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // The clear ends on the cycle that writes the last address.
  always_comb begin
    w_nextState = r_state;
    if (r_state == ST_INIT && r_cnt == '1) begin
      w_nextState = ST_RUN;
    end
  end

  assign w_inInit     = (r_state == ST_INIT);
  assign w_outOfRange = (pc >> ADDR_W) != 32'd0;
  assign w_accept     = !rst && (r_state == ST_RUN) && fetch_req && !stall;

  assign w_we    = !rst && (w_inInit || ld_en);
  assign w_waddr = w_inInit ? r_cnt : ld_addr;
  assign w_wdata = w_inInit ? HALT_WORD : ld_data;
  assign w_re    = w_accept && !w_outOfRange;

  instr_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (pc[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );

  // The RAM read register is not reset, so r_loaded masks it to zero until the first fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
      r_selHalt <= 1'b0;
      r_loaded  <= 1'b0;
    end else if (!stall) begin
      r_valid <= w_accept;
      r_fault <= w_accept && w_outOfRange;
      if (w_accept) begin
        r_selHalt <= w_outOfRange;
        r_loaded  <= 1'b1;
      end
    end
  end

  assign inst       = !r_loaded ? '0 : (r_selHalt ? HALT_WORD : w_rdata);
  assign inst_valid = r_valid;
  assign fault      = r_fault;
  assign busy       = w_inInit;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Randomised scoreboard bench for instr_mem_sync with a small depth so the
// clear sequence, range checks and stall hold are all reachable quickly.
module tb_instr_mem_sync;
  import instr_mem_sync_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam logic [31:0] HALT_W = {OP_HALT, 27'd0};

  typedef struct packed {
    logic [31:0] inst;
    logic        fault;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] pc = '0;
  logic        stall = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fault;
  logic        ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        busy;

  resp_t       expQ[$];
  logic [31:0] refMem [DEPTH];
  int          initLeft = 0;
  bit          refValid = 1'b0;
  resp_t       refResp = '0;
  int          nChecks = 0;
  int          nPassed = 0;
  bit          monitorOn = 1'b0;

  always #5 clk = ~clk;

  instr_mem_sync #(
    .WIDTH          (32),
    .ADDR_W         (AW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .pc         (pc),
    .stall      (stall),
    .inst       (inst),
    .inst_valid (inst_valid),
    .fault      (fault),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .busy       (busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPassed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference behaviour for one rising edge, from the current input values.
  function automatic void modelEdge();
    if (rst) begin
      initLeft = DEPTH;
      refValid = 1'b0;
      refResp  = '0;
    end else if (initLeft > 0) begin
      refMem[DEPTH - initLeft] = HALT_W;
      initLeft--;
    end else begin
      if (!stall) begin
        if (fetch_req) begin
          if (pc >= 32'(DEPTH)) refResp = '{inst: HALT_W, fault: 1'b1};
          else                  refResp = '{inst: refMem[int'(pc)], fault: 1'b0};
          refValid = 1'b1;
          expQ.push_back(refResp);
        end else begin
          refValid      = 1'b0;
          refResp.fault = 1'b0;
        end
      end else if (refValid) begin
        expQ.push_back(refResp);
      end
      if (ld_en) refMem[int'(ld_addr)] = ld_data;
    end
  endfunction

  task automatic applyStimulus(input logic iRst, input logic iFetch, input logic [31:0] iPc,
                               input logic iStall, input logic iLd, input logic [AW-1:0] iAddr,
                               input logic [31:0] iData);
    rst       = iRst;
    fetch_req = iFetch;
    pc        = iPc;
    stall     = iStall;
    ld_en     = iLd;
    ld_addr   = iAddr;
    ld_data   = iData;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, '0, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] iPc);
    applyStimulus(1'b0, 1'b1, iPc, 1'b0, 1'b0, '0, 32'd0);
  endtask

  // Counts edges after rst release until busy drops; random fetch/load traffic is optional.
  task automatic waitInit(input string name, input bit noisy);
    int n = 0;
    do begin
      if (noisy)
        applyStimulus(1'b0, 1'b1, $urandom_range(15, 0), 1'b0, 1'b1, AW'($urandom), $urandom);
      else
        idle();
      n++;
    end while (busy === 1'b1 && n < 40);
    checkOutput(name, 64'(n), 64'(DEPTH));
  endtask

  function automatic logic [31:0] progWord(input logic [4:0] op, input logic [26:0] imm);
    return {op, imm};
  endfunction

  // Scoreboard side: exactly one expected response per edge that should produce inst_valid.
  always @(negedge clk) begin
    resp_t e;
    if (monitorOn) begin
      checkOutput("busy", 64'(busy), 64'(initLeft > 0));
      checkOutput("inst_valid", 64'(inst_valid), 64'(expQ.size() > 0));
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        if (inst_valid === 1'b1) begin
          checkOutput("inst", 64'(inst), 64'(e.inst));
          checkOutput("fault", 64'(fault), 64'(e.fault));
        end
      end else begin
        checkOutput("faultIdle", 64'(fault), 64'd0);
      end
    end
  end

  initial begin
    logic [31:0] prog [7];
    prog[0] = progWord(OP_MOV, 27'h0000_101);
    prog[1] = progWord(OP_MOV, 27'h0000_205);
    prog[2] = progWord(OP_MPY, 27'h0012_300);
    prog[3] = progWord(OP_ADD, 27'h0011_001);
    prog[4] = progWord(OP_CMP, 27'h0010_200);
    prog[5] = progWord(OP_BR,  27'h7FF_FFFD);
    prog[6] = progWord(OP_HALT, 27'h0);

    applyStimulus(1'b1, 1'b1, 32'd3, 1'b0, 1'b1, 4'd2, 32'h1234_5678);
    monitorOn = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, '0, 32'd0);
    checkOutput("rstInst", 64'(inst), 64'd0);
    checkOutput("rstValid", 64'(inst_valid), 64'd0);
    checkOutput("rstFault", 64'(fault), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd1);

    waitInit("initCycles", 1'b0);
    for (int i = 0; i < DEPTH; i++) fetch(32'(i));
    idle();

    for (int i = 0; i < 7; i++)
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, AW'(i), prog[i]);
    for (int i = 0; i < 7; i++) fetch(32'(i));
    idle();

    fetch(32'd16);
    fetch(32'hFFFF_FFFF);
    fetch(32'd15);
    idle();

    applyStimulus(1'b0, 1'b1, 32'd3, 1'b0, 1'b1, 4'd3, 32'hA5A5_A5A5);
    fetch(32'd3);
    checkOutput("rbwNewWord", 64'(refMem[3]), 64'h0000_0000_A5A5_A5A5);
    idle();

    fetch(32'd2);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 32'd5, 1'b1, 1'b0, '0, 32'd0);
    idle();
    idle();

    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, '0, 32'd0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b1, 32'd1, 1'b0, 1'b1, 4'd1, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, '0, 32'd0);
    waitInit("reInitCycles", 1'b1);
    for (int i = 0; i < DEPTH; i++) fetch(32'(i));
    idle();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] rPc;
      rPc = ($urandom_range(7, 0) == 0) ? $urandom : 32'($urandom_range(15, 0));
      applyStimulus(1'b0, $urandom_range(3, 0) != 0, rPc, $urandom_range(4, 0) == 0,
                    $urandom_range(2, 0) == 0, AW'($urandom), $urandom);
    end
    idle();
    idle();
    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the nemesys core. It replaces the combinational ROM used for fetch.
- Adds a runtime program-load write port and an optional post-reset clear-to-HALT sequence.
- Fetch has one-cycle latency, a stall hold, and an out-of-range fault indication.
- Sits between the fetch stage (PC generator) and decode. The load port is driven by the testbench or a future bootloader.

Parameters:
- WIDTH, `WIDTH (32): instruction word width in bits.
- ADDR_W, 8: word-address width. DEPTH = 2**ADDR_W words.
- CLEAR_ON_RESET, 1: when 1, after reset every word is written with the HALT word before fetch is enabled. When 0, the block enters RUN immediately and memory contents are undefined.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request; pc is sampled this cycle.
- pc  in  32  word-indexed program counter (not byte-indexed).
- stall  in  1  holds inst, inst_valid and fault unchanged; new fetch_req is ignored.
- inst  out  WIDTH  fetched instruction word.
- inst_valid  out  1  inst/fault carry the response to the request accepted in the previous cycle.
- fault  out  1  the accepted pc was >= DEPTH; qualified by inst_valid.
- ld_en  in  1  load-port write enable.
- ld_addr  in  ADDR_W  load-port word address.
- ld_data  in  WIDTH  load-port write data.
- busy  out  1  high while the clear sequence runs; fetch and load are ignored.

Behaviour:
- Reset (rst=1 on a clock edge):
  - inst=0, inst_valid=0, fault=0.
  - Clear counter = 0.
  - State = INIT if CLEAR_ON_RESET, else RUN.
  - busy=1 in INIT.
- rst takes priority over every other input in the same cycle.
- FSM states: INIT and RUN.
  - INIT: each cycle write HALT_WORD to mem[cnt], then cnt++.
  - Leave INIT for RUN on the cycle that writes address DEPTH-1; busy falls on the next edge. INIT therefore lasts exactly DEPTH cycles after rst deasserts.
  - RUN: remains until the next rst.
  - rst asserted mid-INIT restarts the clear at address 0.
- During INIT, fetch_req and ld_en are ignored: no write, inst_valid stays 0.
- Fetch in RUN with stall=0 and fetch_req=1:
  - On the next edge, inst_valid=1.
  - In range (pc < DEPTH): inst=mem[pc[ADDR_W-1:0]], fault=0.
  - Out of range (any pc bit >= ADDR_W set): inst=HALT_WORD, fault=1. Memory is not read; there is no wrap-around.
  - Latency is exactly 1 cycle. Back-to-back requests give one response per cycle.
- Fetch in RUN with stall=0 and fetch_req=0: inst_valid=0 and fault=0 on the next edge; inst holds its last value.
- stall=1: inst, inst_valid and fault hold. A fetch_req in the same cycle is dropped; the requester must re-present it after stall falls. The load port stays active during stall.
- Load in RUN with ld_en=1: mem[ld_addr] <= ld_data on the edge. ld_addr is always in range.
- Simultaneous fetch and load to the same address: read-before-write. The fetch returns the old word; the new word is visible from the next request onward.
- HALT_WORD is {`HALT, (WIDTH-5)'d0}.

Decomposition:
- defines.vh gains `IMEM_ADDR_W (default 8) and `HALT_WORD alongside the existing opcode and `WIDTH defines. Opcodes and condition codes stay in defines.vh.
- Sub-module instr_ram: simple dual-port RAM (one write port; one synchronous read port with read-before-write), parametrised by WIDTH and ADDR_W, inferable as block RAM.
- instr_mem_sync holds the FSM, the clear counter, the range check, the fault/HALT mux, and the stall hold register.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_W=4 -> busy=1 for exactly 16 cycles after rst falls. Then fetch pc=0..15 each returns HALT_WORD, fault=0, one cycle after request.
- Load the 7-word loop program (MOV/MOV/MPY/ADD/CMP/BR/HALT) at addresses 0..6, then fetch pc=0..6 back-to-back -> 7 consecutive inst_valid cycles with the matching words in order, 1-cycle latency.
- Fetch pc=16 and pc=32'hFFFF_FFFF with ADDR_W=4 -> inst=HALT_WORD, fault=1, inst_valid=1. Fetch pc=15 next -> fault=0.
- Same cycle: ld_en, ld_addr=3, ld_data=32'hA5A5_A5A5, plus fetch_req pc=3 -> old word returned. Next fetch pc=3 -> 32'hA5A5_A5A5.
- Fetch pc=2, then assert stall for 3 cycles with fetch_req=1, pc=5 -> inst holds mem[2] with inst_valid=1 for all 3 cycles, and pc=5 is never returned.
- Assert rst at INIT cycle 5, hold 1 cycle, then release -> busy lasts a full DEPTH cycles again. fetch_req and ld_en during INIT produce no inst_valid and no write (verify by fetching after INIT -> HALT_WORD).
